// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback path: result-source selects, load
// funct3 codes and the writeback FSM state type.
package riscv_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction: picks the byte/half/word/double
// addressed by the offset from an aligned doubleword and sign/zero-extends it.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] word_lane;

    // Halfword and word lanes ignore the low offset bits (naturally aligned).
    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = rdata[{offset[2:1], 4'b0000} +: 16];
    assign word_lane = rdata[{offset[2], 5'b00000} +: 32];

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LW:   result = {{(XLEN-32){word_lane[31]}}, word_lane};
            F3_LD:   result = rdata;
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
            F3_LWU:  result = {{(XLEN-32){1'b0}}, word_lane};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Register-file write side: holds one completed instruction, waits for load
// data when needed, and drives a registered write port plus a retire pulse.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_regwrite,
    input  logic [1:0]      ex_wb_sel,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_pc_plus4,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            Control_RegWrite,
    output logic [4:0]      WriteRegister,
    output logic [XLEN-1:0] WriteData,
    output logic            retire,
    output wb_state_t       fsm_state
);

    // Handshake: an instruction transfers on a rising edge where ex_valid
    // and ex_ready are both high; ex_ready is high only in IDLE.

    wb_state_t       state_q, state_d;
    logic [4:0]      rd_q;
    logic            regwrite_q;
    logic [2:0]      funct3_q;
    logic [2:0]      offset_q;

    logic            enter_write;
    logic [4:0]      wr_rd;
    logic            wr_regwrite;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] load_result;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3 (funct3_q),
        .offset (offset_q),
        .rdata  (mem_rdata),
        .result (load_result)
    );

    assign ex_ready  = (state_q == ST_IDLE);
    assign fsm_state = state_q;

    // The write-port registers are loaded on the edge that enters WRITE, so
    // they are already valid for the whole WRITE cycle.
    always_comb begin
        state_d     = state_q;
        enter_write = 1'b0;
        wr_rd       = rd_q;
        wr_regwrite = regwrite_q;
        wr_data     = WriteData;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_wb_sel == WB_MEM) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        state_d     = ST_WRITE;
                        enter_write = 1'b1;
                        wr_rd       = ex_rd;
                        wr_regwrite = ex_regwrite;
                        // Reserved select 3 falls through to the ALU result.
                        wr_data     = (ex_wb_sel == WB_PC4) ? ex_pc_plus4 : ex_alu_result;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d     = ST_WRITE;
                    enter_write = 1'b1;
                    wr_data     = load_result;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            rd_q             <= '0;
            regwrite_q       <= 1'b0;
            funct3_q         <= '0;
            offset_q         <= '0;
            Control_RegWrite <= 1'b0;
            retire           <= 1'b0;
            WriteRegister    <= '0;
            WriteData        <= '0;
        end else begin
            state_q <= state_d;
            if (ex_valid && ex_ready) begin
                rd_q       <= ex_rd;
                regwrite_q <= ex_regwrite;
                funct3_q   <= ex_funct3;
                offset_q   <= ex_alu_result[2:0];
            end
            // x0 is hardwired to zero, so its write enable is suppressed here.
            Control_RegWrite <= enter_write && wr_regwrite && (wr_rd != 5'd0);
            retire           <= enter_write;
            if (enter_write) begin
                WriteRegister <= wr_rd;
                WriteData     <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases then randomized
// transactions compared against a byte-arithmetic reference model.
module tb_writeback_stage;
    import riscv_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_regwrite;
    logic [1:0]      ex_wb_sel;
    logic [2:0]      ex_funct3;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_pc_plus4;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            Control_RegWrite;
    logic [4:0]      WriteRegister;
    logic [XLEN-1:0] WriteData;
    logic            retire;
    wb_state_t       fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] last_data = '0;
    logic [4:0]  last_rd   = '0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_regwrite      (ex_regwrite),
        .ex_wb_sel        (ex_wb_sel),
        .ex_funct3        (ex_funct3),
        .ex_rd            (ex_rd),
        .ex_alu_result    (ex_alu_result),
        .ex_pc_plus4      (ex_pc_plus4),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .Control_RegWrite (Control_RegWrite),
        .WriteRegister    (WriteRegister),
        .WriteData        (WriteData),
        .retire           (retire),
        .fsm_state        (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Loads: size in bytes, offset rounded down to that size, shift and mask.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] rdata);
        int nbytes;
        bit sgn;
        int base;
        logic [63:0] v;
        logic [63:0] mask;
        case (f3)
            3'd0: begin nbytes = 1; sgn = 1; end
            3'd1: begin nbytes = 2; sgn = 1; end
            3'd2: begin nbytes = 4; sgn = 1; end
            3'd3: begin nbytes = 8; sgn = 0; end
            3'd4: begin nbytes = 1; sgn = 0; end
            3'd5: begin nbytes = 2; sgn = 0; end
            3'd6: begin nbytes = 4; sgn = 0; end
            default: return 64'd0;
        endcase
        base = (int'(off) / nbytes) * nbytes;
        v    = rdata >> (base * 8);
        mask = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (nbytes * 8)) - 64'd1);
        v    = v & mask;
        if (sgn && v[nbytes*8-1]) v = v | ~mask;
        return v;
    endfunction

    // Entry and exit point of every task: 1 time unit after a rising edge.
    task automatic txn(input bit rw, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] pc4,
                       input int delay, input logic [63:0] rdata,
                       input bit spurious, input bit early);
        logic [63:0] exp_data;
        logic        exp_we;
        if (spurious) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rand64();
            @(posedge clk) #1;
            mem_rvalid = 1'b0;
            check("spur_we", Control_RegWrite, 0);
            check("spur_retire", retire, 0);
            check("spur_hold", WriteData, last_data);
            check("spur_ready", ex_ready, 1);
        end
        ex_valid      = 1'b1;
        ex_regwrite   = rw;
        ex_wb_sel     = sel;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_alu_result = alu;
        ex_pc_plus4   = pc4;
        if (early && sel == WB_MEM) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rand64();
        end
        @(negedge clk);
        check("accept_ready", ex_ready, 1);
        @(posedge clk) #1;
        ex_valid   = 1'b0;
        mem_rvalid = 1'b0;
        ex_alu_result = rand64();
        ex_funct3     = 3'($urandom_range(0, 7));
        if (sel == WB_MEM) begin
            exp_data = ref_load(f3, alu[2:0], rdata);
            repeat (delay - 1) begin
                @(negedge clk);
                check("wait_ready", ex_ready, 0);
                check("wait_retire", retire, 0);
                @(posedge clk) #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            check("rvalid_ready", ex_ready, 0);
            @(posedge clk) #1;
            mem_rvalid = 1'b0;
            mem_rdata  = rand64();
        end else begin
            exp_data = (sel == WB_PC4) ? pc4 : alu;
        end
        exp_we = rw && (rd != 5'd0);
        @(negedge clk);
        check("wr_we", Control_RegWrite, exp_we);
        check("wr_rd", WriteRegister, rd);
        check("wr_data", WriteData, exp_data);
        check("wr_retire", retire, 1);
        check("wr_ready", ex_ready, 0);
        check("wr_state", 64'(fsm_state), 64'(ST_WRITE));
        @(posedge clk) #1;
        check("post_we", Control_RegWrite, 0);
        check("post_retire", retire, 0);
        check("post_ready", ex_ready, 1);
        check("post_hold_data", WriteData, exp_data);
        check("post_hold_rd", WriteRegister, rd);
        last_data = exp_data;
        last_rd   = rd;
    endtask

    initial begin
        reset = 1'b1; ex_valid = 0; ex_regwrite = 0; ex_wb_sel = 0; ex_funct3 = 0;
        ex_rd = 0; ex_alu_result = 0; ex_pc_plus4 = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ex_ready, 1);
        check("rst_we", Control_RegWrite, 0);
        check("rst_retire", retire, 0);
        check("rst_rd", WriteRegister, 0);
        check("rst_data", WriteData, 0);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        reset = 1'b0;
        @(posedge clk) #1;

        // Directed cases.
        txn(1, WB_ALU, 3'd0, 5'd5, 64'h1234, 64'h0, 1, 64'h0, 0, 0);
        txn(1, WB_ALU, 3'd0, 5'd0, 64'hDEAD, 64'h0, 1, 64'h0, 0, 0);
        txn(1, WB_PC4, 3'd0, 5'd1, 64'h77, 64'h8000_0004, 1, 64'h0, 0, 0);
        txn(1, 2'd3, 3'd0, 5'd2, 64'hABCD, 64'h44, 1, 64'h0, 0, 0);
        txn(0, WB_ALU, 3'd0, 5'd9, 64'h55, 64'h0, 1, 64'h0, 0, 0);
        txn(1, WB_MEM, F3_LB, 5'd6, 64'h1003, 64'h0, 1, 64'h0000_0000_8000_0000, 0, 0);
        check("lb_sign", last_data, 64'hFFFF_FFFF_FFFF_FF80);
        txn(1, WB_MEM, F3_LBU, 5'd6, 64'h1003, 64'h0, 1, 64'h0000_0000_8000_0000, 0, 0);
        check("lbu_zero", last_data, 64'h80);
        txn(1, WB_MEM, F3_LW, 5'd7, 64'h2004, 64'h0, 2, 64'h9ABC_DEF0_1234_5678, 0, 0);
        check("lw_sign", last_data, 64'hFFFF_FFFF_9ABC_DEF0);
        txn(1, WB_MEM, F3_LWU, 5'd7, 64'h2004, 64'h0, 2, 64'h9ABC_DEF0_1234_5678, 0, 0);
        check("lwu_zero", last_data, 64'h0000_0000_9ABC_DEF0);
        txn(1, WB_MEM, F3_LD, 5'd8, 64'h3000, 64'h0, 5, 64'hCAFE_F00D_0BAD_BEEF, 1, 1);
        txn(1, WB_MEM, 3'b111, 5'd8, 64'h3000, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        txn(1, WB_MEM, F3_LH, 5'd10, 64'h3006, 64'h0, 1, 64'h8001_0000_0000_0000, 0, 0);

        // Reset while waiting for load data aborts the write.
        ex_valid = 1; ex_regwrite = 1; ex_wb_sel = WB_MEM; ex_funct3 = F3_LD;
        ex_rd = 5'd12; ex_alu_result = 64'h40;
        @(posedge clk) #1;
        ex_valid = 0;
        check("rstm_state_wait", 64'(fsm_state), 64'(ST_WAIT_MEM));
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        check("rstm_state", 64'(fsm_state), 64'(ST_IDLE));
        check("rstm_ready", ex_ready, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1111_2222_3333_4444;
        @(posedge clk) #1;
        mem_rvalid = 1'b0;
        check("rstm_we", Control_RegWrite, 0);
        check("rstm_retire", retire, 0);
        check("rstm_data", WriteData, 0);
        check("rstm_state2", 64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk) #1;
        check("rstm_retire2", retire, 0);
        last_data = '0;

        // Randomized transactions.
        for (int i = 0; i < 300; i++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), rand64(), rand64(), int'($urandom_range(1, 6)),
                rand64(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Register-file write side of the RISC-V core: accepts one completed instruction per transaction from the execute/memory side, waits for load data where needed, selects and sign/zero-extends the result, and drives the register file's write port. It is the writer counterpart of the register-file read path (`reg1`/`reg2` → `ReadData1`/`ReadData2`). It holds a single instruction, so issue stalls on `ex_ready` while a load is outstanding.

## Interface
Parameters:
- `XLEN`, 64: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  instruction result offered.
- `ex_ready`  out  1  block can accept.
- `ex_regwrite`  in  1  instruction writes `rd`.
- `ex_wb_sel`  in  2  result source: 0 ALU, 1 MEM, 2 PC+4; 3 is reserved.
- `ex_funct3`  in  3  load type (LB/LH/LW/LD/LBU/LHU/LWU).
- `ex_rd`  in  5  destination register.
- `ex_alu_result`  in  XLEN  ALU result; bits [2:0] give the load byte offset.
- `ex_pc_plus4`  in  XLEN  link value.
- `mem_rvalid`  in  1  load data valid, single-cycle pulse.
- `mem_rdata`  in  XLEN  aligned doubleword from data memory.
- `Control_RegWrite`  out  1  register-file write enable.
- `WriteRegister`  out  5  register-file write address.
- `WriteData`  out  XLEN  register-file write data.
- `retire`  out  1  one-cycle pulse per completed instruction.

## Operation
- The FSM has three states: IDLE, WAIT_MEM and WRITE.
- IDLE:
  - `ex_ready`=1.
  - On `ex_valid`, capture rd, regwrite, wb_sel, funct3, alu_result and pc_plus4.
  - wb_sel=MEM → WAIT_MEM.
  - Otherwise, load the selected value into the data register → WRITE.
- WAIT_MEM:
  - `ex_ready`=0.
  - On `mem_rvalid`, extract the lane from `mem_rdata` using offset alu_result[2:0]:
    - LB/LBU: byte at offset.
    - LH/LHU: halfword at offset[2:1].
    - LW/LWU: word at offset[2].
    - LD: whole doubleword.
  - Sign-extend LB/LH/LW; zero-extend LBU/LHU/LWU. Register the result → WRITE.
  - An unsupported funct3 (011 is LD; 111) writes zero.
- WRITE:
  - `ex_ready`=0.
  - Drive `WriteRegister`=rd and `WriteData`=data register.
  - `Control_RegWrite` = regwrite && (rd≠0); x0 is never written.
  - `retire`=1. Next state is IDLE.
- Reserved wb_sel=3 is treated as ALU.
- `mem_rvalid` seen in IDLE or WRITE is ignored; no data is captured.
- `WriteRegister`/`WriteData` hold their last values outside WRITE. Only `Control_RegWrite` qualifies them.

## Timing
- Reset values:
  - state=IDLE, `ex_ready`=1 (combinational from state).
  - `Control_RegWrite`=0, `retire`=0.
  - `WriteRegister`=0, `WriteData`=0.
- Non-load latency: accepted at edge N; WRITE outputs are valid during cycle N+1; the register file commits at edge N+2. `ex_ready` returns at N+2, so throughput is one instruction per 2 cycles.
- Load latency: `mem_rvalid` high at edge M; write is asserted during cycle M+1.
- `mem_rvalid` in the same cycle the load is accepted is not captured. Memory must respond no earlier than the cycle after acceptance.
- `reset` asserted mid-transaction (WAIT_MEM or WRITE) aborts the transaction with no register-file write, and returns to IDLE at the next edge.
- All outputs are registered except `ex_ready`.

## Structure
- Package `riscv_pkg` holds:
  - `wb_sel` encodings: WB_ALU=0, WB_MEM=1, WB_PC4=2.
  - Load funct3 constants: F3_LB=000, F3_LH=001, F3_LW=010, F3_LD=011, F3_LBU=100, F3_LHU=101, F3_LWU=110.
  - State encoding.
- Sub-module `load_extend`: purely combinational (funct3, offset, rdata → XLEN result), reusable by the data-memory path.

## Test plan
- ALU write: rd=5, alu_result=0x1234, wb_sel=ALU. Expect `Control_RegWrite`=1, `WriteRegister`=5, `WriteData`=0x1234 the cycle after acceptance, `retire`=1, `ex_ready`=1 two cycles later.
- x0 suppression: rd=0, regwrite=1. Expect `Control_RegWrite`=0, `retire`=1.
- LB sign: offset 3, rdata=0x0000_0000_8000_0000 (byte 3 = 0x80). Expect `WriteData`=0xFFFF_FFFF_FFFF_FF80. Repeat with LBU: expect 0x80.
- LW/LWU at offset 4, rdata=0x9ABC_DEF0_1234_5678 (upper word 0x9ABC_DEF0). LW: expect 0xFFFF_FFFF_9ABC_DEF0. LWU: expect 0x0000_0000_9ABC_DEF0.
- Load with a 5-cycle memory delay:
  - `ex_ready`=0 throughout the wait.
  - A spurious `mem_rvalid` sent in IDLE beforehand is ignored.
  - The write occurs exactly one cycle after the real `mem_rvalid`.
- Reset during WAIT_MEM, then `mem_rvalid` arrives: no `Control_RegWrite`, no `retire`, state returns to IDLE with `ex_ready`=1.
